// File: rtl/conv_layer_loader.sv
// conv_layer_loader: streams the input feature map and conv kernels from a
// source memory port into the FM, weight and bias RAMs. It does one full
// initial load, then refills one kernel slot per update request, and lets a
// host write the FM RAM whenever the loader is not using that port.
module conv_layer_loader #(
    parameter int DATA_WIDTH     = 16,
    parameter int FM_WORDS       = 154587,
    parameter int KERNEL_WORDS   = 363,
    parameter int KERNEL_NUM     = 96,
    parameter int SLOTS          = 2,
    parameter int SLOT_STRIDE    = 512,
    parameter int FM_ADDR_WIDTH  = 19,
    parameter int W_ADDR_WIDTH   = 13,
    parameter int B_ADDR_WIDTH   = 1,
    parameter int SRC_ADDR_WIDTH = 20,
    parameter int FM_SRC_BASE    = 0,
    parameter int W_SRC_BASE     = FM_WORDS,
    parameter int B_SRC_BASE     = FM_WORDS + KERNEL_NUM * KERNEL_WORDS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               init_start,
    input  logic                               upd_start,
    input  logic [B_ADDR_WIDTH-1:0]            upd_slot,
    output logic                               src_rd_en,
    output logic [SRC_ADDR_WIDTH-1:0]          src_addr,
    input  logic [DATA_WIDTH-1:0]              src_rdata,
    output logic                               fm_we,
    output logic [FM_ADDR_WIDTH-1:0]           fm_waddr,
    output logic [DATA_WIDTH-1:0]              fm_wdata,
    output logic                               w_we,
    output logic [W_ADDR_WIDTH-1:0]            w_waddr,
    output logic [DATA_WIDTH-1:0]              w_wdata,
    output logic                               b_we,
    output logic [B_ADDR_WIDTH-1:0]            b_waddr,
    output logic [DATA_WIDTH-1:0]              b_wdata,
    input  logic                               host_we,
    input  logic [FM_ADDR_WIDTH-1:0]           host_addr,
    input  logic [DATA_WIDTH-1:0]              host_data,
    output logic                               host_ready,
    output logic                               busy,
    output logic                               init_done,
    output logic                               upd_done,
    output logic                               upd_err,
    output logic [$clog2(KERNEL_NUM+1)-1:0]    kernel_idx
);

    localparam int CNT_MAX   = (FM_WORDS > KERNEL_WORDS) ? FM_WORDS : KERNEL_WORDS;
    localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);
    localparam int KI_WIDTH  = $clog2(KERNEL_NUM + 1);
    localparam int RA_TMP    = (FM_ADDR_WIDTH > W_ADDR_WIDTH) ? FM_ADDR_WIDTH : W_ADDR_WIDTH;
    localparam int RA_WIDTH  = (RA_TMP > B_ADDR_WIDTH) ? RA_TMP : B_ADDR_WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FM    = 3'd1;
    localparam logic [2:0] S_WGT   = 3'd2;
    localparam logic [2:0] S_BIAS  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [1:0] T_FM = 2'd0;
    localparam logic [1:0] T_W  = 2'd1;
    localparam logic [1:0] T_B  = 2'd2;

    localparam logic [CNT_WIDTH-1:0]    FM_LAST   = CNT_WIDTH'(FM_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0]    W_LAST    = CNT_WIDTH'(KERNEL_WORDS - 1);
    localparam logic [B_ADDR_WIDTH-1:0] SLOT_LAST = B_ADDR_WIDTH'(SLOTS - 1);

    // Source address of word 0 of kernel k.
    function automatic logic [SRC_ADDR_WIDTH-1:0] w_src(input logic [KI_WIDTH-1:0] k);
        return SRC_ADDR_WIDTH'(W_SRC_BASE + int'(k) * KERNEL_WORDS);
    endfunction

    // Weight-RAM address of word 0 of slot s.
    function automatic logic [RA_WIDTH-1:0] slot_base(input logic [B_ADDR_WIDTH-1:0] s);
        return RA_WIDTH'(int'(s) * SLOT_STRIDE);
    endfunction

    // Control / read-stage state
    logic [2:0]                state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [B_ADDR_WIDTH-1:0]   slot_q, slot_d;
    logic [KI_WIDTH-1:0]       kidx_q, kidx_d;
    logic                      init_mode_q, init_mode_d;
    logic                      init_done_q, init_done_d;
    logic                      upd_done_q, upd_done_d;
    logic                      upd_err_q, upd_err_d;
    logic                      busy_q, busy_d;
    logic                      host_ready_q, host_ready_d;
    logic                      rd_en_q, rd_en_d;
    logic [SRC_ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
    logic [1:0]                rd_tgt_q, rd_tgt_d;
    logic [RA_WIDTH-1:0]       rd_waddr_q, rd_waddr_d;

    // Write stage
    logic                      host_acc_s;
    logic                      fm_we_q, fm_we_d;
    logic                      fm_host_q, fm_host_d;
    logic [FM_ADDR_WIDTH-1:0]  fm_waddr_q, fm_waddr_d;
    logic [DATA_WIDTH-1:0]     fm_hdata_q, fm_hdata_d;
    logic                      w_we_q, w_we_d;
    logic [W_ADDR_WIDTH-1:0]   w_waddr_q, w_waddr_d;
    logic                      b_we_q, b_we_d;
    logic [B_ADDR_WIDTH-1:0]   b_waddr_q, b_waddr_d;

    // Sequencer: chooses the next read and the RAM address its data lands at.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        slot_d      = slot_q;
        kidx_d      = kidx_q;
        init_mode_d = init_mode_q;
        init_done_d = init_done_q;
        upd_done_d  = 1'b0;
        upd_err_d   = 1'b0;
        rd_en_d     = 1'b0;
        src_addr_d  = src_addr_q;
        rd_tgt_d    = rd_tgt_q;
        rd_waddr_d  = rd_waddr_q;
        case (state_q)
            S_IDLE: begin
                if (init_start) begin
                    // init wins over a simultaneous update, which is dropped
                    state_d     = S_FM;
                    cnt_d       = '0;
                    slot_d      = '0;
                    kidx_d      = '0;
                    init_mode_d = 1'b1;
                    init_done_d = 1'b0;
                    rd_en_d     = 1'b1;
                    src_addr_d  = SRC_ADDR_WIDTH'(FM_SRC_BASE);
                    rd_tgt_d    = T_FM;
                    rd_waddr_d  = '0;
                end else if (upd_start) begin
                    if (!init_done_q || int'(kidx_q) >= KERNEL_NUM || int'(upd_slot) >= SLOTS) begin
                        upd_err_d = 1'b1;
                    end else begin
                        state_d     = S_WGT;
                        cnt_d       = '0;
                        slot_d      = upd_slot;
                        init_mode_d = 1'b0;
                        rd_en_d     = 1'b1;
                        src_addr_d  = w_src(kidx_q);
                        rd_tgt_d    = T_W;
                        rd_waddr_d  = slot_base(upd_slot);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FM: begin
                rd_en_d = 1'b1;
                if (cnt_q == FM_LAST) begin
                    state_d    = S_WGT;
                    cnt_d      = '0;
                    src_addr_d = w_src(kidx_q);
                    rd_tgt_d   = T_W;
                    rd_waddr_d = slot_base(slot_q);
                end else begin
                    cnt_d      = cnt_q + CNT_WIDTH'(1);
                    src_addr_d = src_addr_q + SRC_ADDR_WIDTH'(1);
                    rd_waddr_d = rd_waddr_q + RA_WIDTH'(1);
                end
            end
            S_WGT: begin
                rd_en_d = 1'b1;
                if (cnt_q == W_LAST) begin
                    state_d    = S_BIAS;
                    src_addr_d = SRC_ADDR_WIDTH'(B_SRC_BASE + int'(kidx_q));
                    rd_tgt_d   = T_B;
                    rd_waddr_d = RA_WIDTH'(slot_q);
                end else begin
                    cnt_d      = cnt_q + CNT_WIDTH'(1);
                    src_addr_d = src_addr_q + SRC_ADDR_WIDTH'(1);
                    rd_waddr_d = rd_waddr_q + RA_WIDTH'(1);
                end
            end
            S_BIAS: begin
                kidx_d = kidx_q + KI_WIDTH'(1);
                if (init_mode_q && slot_q != SLOT_LAST) begin
                    // initial load continues with kernel k+1 into slot k+1
                    state_d    = S_WGT;
                    slot_d     = slot_q + B_ADDR_WIDTH'(1);
                    cnt_d      = '0;
                    rd_en_d    = 1'b1;
                    src_addr_d = w_src(kidx_q + KI_WIDTH'(1));
                    rd_tgt_d   = T_W;
                    rd_waddr_d = slot_base(slot_q + B_ADDR_WIDTH'(1));
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                if (init_mode_q) begin
                    init_done_d = 1'b1;
                end else begin
                    upd_done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they line up with it.
    always_comb begin
        busy_d       = (state_d != S_IDLE);
        host_ready_d = !((state_d == S_FM) || (state_d == S_DRAIN && state_q == S_FM));
    end

    // Write stage: data returned this cycle is written at the address captured with its read.
    always_comb begin
        host_acc_s = host_we && host_ready_q;
        fm_we_d    = (rd_en_q && rd_tgt_q == T_FM) || host_acc_s;
        fm_host_d  = host_acc_s;
        fm_hdata_d = fm_hdata_q;
        fm_waddr_d = fm_waddr_q;
        if (host_acc_s) begin
            fm_waddr_d = host_addr;
            fm_hdata_d = host_data;
        end else if (rd_en_q && rd_tgt_q == T_FM) begin
            fm_waddr_d = rd_waddr_q[FM_ADDR_WIDTH-1:0];
        end else begin
            fm_waddr_d = fm_waddr_q;
        end
        w_we_d    = rd_en_q && (rd_tgt_q == T_W);
        w_waddr_d = w_we_d ? rd_waddr_q[W_ADDR_WIDTH-1:0] : w_waddr_q;
        b_we_d    = rd_en_q && (rd_tgt_q == T_B);
        b_waddr_d = b_we_d ? rd_waddr_q[B_ADDR_WIDTH-1:0] : b_waddr_q;
    end

    // State registers with synchronous active-low reset; reset aborts any load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            slot_q       <= '0;
            kidx_q       <= '0;
            init_mode_q  <= 1'b0;
            init_done_q  <= 1'b0;
            upd_done_q   <= 1'b0;
            upd_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            host_ready_q <= 1'b1;
            rd_en_q      <= 1'b0;
            src_addr_q   <= '0;
            rd_tgt_q     <= T_FM;
            rd_waddr_q   <= '0;
            fm_we_q      <= 1'b0;
            fm_host_q    <= 1'b0;
            fm_waddr_q   <= '0;
            fm_hdata_q   <= '0;
            w_we_q       <= 1'b0;
            w_waddr_q    <= '0;
            b_we_q       <= 1'b0;
            b_waddr_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            kidx_q       <= kidx_d;
            init_mode_q  <= init_mode_d;
            init_done_q  <= init_done_d;
            upd_done_q   <= upd_done_d;
            upd_err_q    <= upd_err_d;
            busy_q       <= busy_d;
            host_ready_q <= host_ready_d;
            rd_en_q      <= rd_en_d;
            src_addr_q   <= src_addr_d;
            rd_tgt_q     <= rd_tgt_d;
            rd_waddr_q   <= rd_waddr_d;
            fm_we_q      <= fm_we_d;
            fm_host_q    <= fm_host_d;
            fm_waddr_q   <= fm_waddr_d;
            fm_hdata_q   <= fm_hdata_d;
            w_we_q       <= w_we_d;
            w_waddr_q    <= w_waddr_d;
            b_we_q       <= b_we_d;
            b_waddr_q    <= b_waddr_d;
        end
    end

    // Source data arrives in the write cycle, so the write data is steered here; it is gated to 0 when idle.
    always_comb begin
        fm_wdata = fm_host_q ? fm_hdata_q : (fm_we_q ? src_rdata : '0);
        w_wdata  = w_we_q ? src_rdata : '0;
        b_wdata  = b_we_q ? src_rdata : '0;
    end

    assign src_rd_en  = rd_en_q;
    assign src_addr   = src_addr_q;
    assign fm_we      = fm_we_q;
    assign fm_waddr   = fm_waddr_q;
    assign w_we       = w_we_q;
    assign w_waddr    = w_waddr_q;
    assign b_we       = b_we_q;
    assign b_waddr    = b_waddr_q;
    assign host_ready = host_ready_q;
    assign busy       = busy_q;
    assign init_done  = init_done_q;
    assign upd_done   = upd_done_q;
    assign upd_err    = upd_err_q;
    assign kernel_idx = kidx_q;

endmodule

// File: tb/tb_conv_layer_loader.sv
// Testbench for conv_layer_loader: small layer, source word at address a is a.
// Expected RAM writes are queued when stimulus is issued; a monitor pops them
// as the DUT writes. Control timing is checked directly by the stimulus.
module tb_conv_layer_loader;

    localparam int DW = 16;
    localparam int FMW = 8;
    localparam int KW = 4;
    localparam int KN = 3;
    localparam int SL = 2;
    localparam int ST = 8;
    localparam int FAW = 4;
    localparam int WAW = 5;
    localparam int BAW = 2;
    localparam int SAW = 8;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           init_start, upd_start;
    logic [BAW-1:0] upd_slot;
    logic           src_rd_en;
    logic [SAW-1:0] src_addr;
    logic [DW-1:0]  src_rdata = '0;
    logic           fm_we, w_we, b_we;
    logic [FAW-1:0] fm_waddr;
    logic [WAW-1:0] w_waddr;
    logic [BAW-1:0] b_waddr;
    logic [DW-1:0]  fm_wdata, w_wdata, b_wdata;
    logic           host_we;
    logic [FAW-1:0] host_addr;
    logic [DW-1:0]  host_data;
    logic           host_ready, busy, init_done, upd_done, upd_err;
    logic [1:0]     kernel_idx;

    wr_t fm_q[$];
    wr_t w_q[$];
    wr_t b_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    conv_layer_loader #(
        .DATA_WIDTH(DW), .FM_WORDS(FMW), .KERNEL_WORDS(KW), .KERNEL_NUM(KN),
        .SLOTS(SL), .SLOT_STRIDE(ST), .FM_ADDR_WIDTH(FAW), .W_ADDR_WIDTH(WAW),
        .B_ADDR_WIDTH(BAW), .SRC_ADDR_WIDTH(SAW), .FM_SRC_BASE(0),
        .W_SRC_BASE(8), .B_SRC_BASE(20)
    ) dut (
        .clk(clk), .rst(rst), .init_start(init_start), .upd_start(upd_start),
        .upd_slot(upd_slot), .src_rd_en(src_rd_en), .src_addr(src_addr),
        .src_rdata(src_rdata), .fm_we(fm_we), .fm_waddr(fm_waddr),
        .fm_wdata(fm_wdata), .w_we(w_we), .w_waddr(w_waddr), .w_wdata(w_wdata),
        .b_we(b_we), .b_waddr(b_waddr), .b_wdata(b_wdata), .host_we(host_we),
        .host_addr(host_addr), .host_data(host_data), .host_ready(host_ready),
        .busy(busy), .init_done(init_done), .upd_done(upd_done),
        .upd_err(upd_err), .kernel_idx(kernel_idx)
    );

    // Clock
    always #5 clk = ~clk;

    // Source memory model: word at address a is a, one-cycle read latency.
    always @(posedge clk) begin
        if (src_rd_en === 1'b1) src_rdata <= DW'(src_addr);
    end

    function automatic wr_t mk(input int a, input int d);
        wr_t r;
        r.addr = 8'(a);
        r.data = 16'(d);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every RAM write must match the oldest expected write for that RAM.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (fm_we === 1'b1) begin
            if (fm_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL fm_unexpected: got addr %0d data %0h expected no write", fm_waddr, fm_wdata);
            end else begin
                e = fm_q.pop_front();
                chk("fm_write", {8'(fm_waddr), fm_wdata}, {e.addr, e.data});
            end
        end
        if (w_we === 1'b1) begin
            if (w_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL w_unexpected: got addr %0d data %0h expected no write", w_waddr, w_wdata);
            end else begin
                e = w_q.pop_front();
                chk("w_write", {8'(w_waddr), w_wdata}, {e.addr, e.data});
            end
        end
        if (b_we === 1'b1) begin
            if (b_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL b_unexpected: got addr %0d data %0h expected no write", b_waddr, b_wdata);
            end else begin
                e = b_q.pop_front();
                chk("b_write", {8'(b_waddr), b_wdata}, {e.addr, e.data});
            end
        end
    end

    task automatic queues_empty(input string tag);
        chk({tag, "_fm_q_left"}, 32'(fm_q.size()), 32'd0);
        chk({tag, "_w_q_left"}, 32'(w_q.size()), 32'd0);
        chk({tag, "_b_q_left"}, 32'(b_q.size()), 32'd0);
    endtask

    // Full initial load; optionally exercises host writes, a simultaneous
    // update request and an update request while busy.
    task automatic run_init(input bit host_test, input bit simul_upd);
        for (int i = 0; i < FMW; i++) fm_q.push_back(mk(i, i));
        for (int s = 0; s < SL; s++) begin
            for (int j = 0; j < KW; j++) w_q.push_back(mk(s * ST + j, 8 + s * KW + j));
            b_q.push_back(mk(s, 20 + s));
        end
        init_start = 1'b1;
        upd_start  = simul_upd;
        upd_slot   = '0;
        tick();
        init_start = 1'b0;
        upd_start  = 1'b0;
        chk("init_busy_c1", 32'(busy), 32'd1);
        chk("init_rd_en_c1", 32'(src_rd_en), 32'd1);
        chk("init_src_addr_c1", 32'(src_addr), 32'd0);
        for (int c = 1; c <= 19; c++) begin
            if (simul_upd && c == 1) chk("simul_no_err", 32'(upd_err), 32'd0);
            if (simul_upd && c == 4) chk("busy_upd_no_err", 32'(upd_err), 32'd0);
            upd_start = (simul_upd && c == 3);
            if (host_test) begin
                if (c <= 8) begin
                    chk("host_ready_fm", 32'(host_ready), 32'd0);
                    host_we = 1'b1; host_addr = 4'd15; host_data = 16'hDEAD;
                end else if (c == 10) begin
                    chk("host_ready_wgt", 32'(host_ready), 32'd1);
                    host_we = 1'b1; host_addr = 4'd5; host_data = 16'hABCD;
                    fm_q.push_back(mk(5, 16'hABCD));
                end else begin
                    host_we = 1'b0;
                end
            end
            if (c == 19) chk("init_busy_c19", 32'(busy), 32'd1);
            tick();
        end
        upd_start = 1'b0;
        host_we   = 1'b0;
        chk("init_busy_c20", 32'(busy), 32'd0);
        chk("init_done_c20", 32'(init_done), 32'd1);
        chk("init_kidx", 32'(kernel_idx), 32'd2);
        tick();
        queues_empty("init");
    endtask

    // Accepted update of kernel k into slot s.
    task automatic run_upd(input int s, input int k);
        for (int j = 0; j < KW; j++) w_q.push_back(mk(s * ST + j, 8 + k * KW + j));
        b_q.push_back(mk(s, 20 + k));
        upd_start = 1'b1;
        upd_slot  = BAW'(s);
        tick();
        upd_start = 1'b0;
        chk("upd_busy_c1", 32'(busy), 32'd1);
        chk("upd_src_addr_c1", 32'(src_addr), 32'(8 + k * KW));
        for (int c = 1; c <= 5; c++) tick();
        chk("upd_busy_c6", 32'(busy), 32'd1);
        chk("upd_done_c6", 32'(upd_done), 32'd0);
        tick();
        chk("upd_done_c7", 32'(upd_done), 32'd1);
        chk("upd_busy_c7", 32'(busy), 32'd0);
        chk("upd_kidx", 32'(kernel_idx), 32'(k + 1));
        tick();
        chk("upd_done_pulse", 32'(upd_done), 32'd0);
        queues_empty("upd");
    endtask

    // Rejected update: error pulse in cycle 1, no reads, stays idle.
    task automatic reject(input int s, input string tag);
        upd_start = 1'b1;
        upd_slot  = BAW'(s);
        tick();
        upd_start = 1'b0;
        chk({tag, "_err"}, 32'(upd_err), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_en"}, 32'(src_rd_en), 32'd0);
        tick();
        chk({tag, "_err_pulse"}, 32'(upd_err), 32'd0);
        tick();
    endtask

    // Directed scenario sequence
    initial begin
        rst = 1'b0; init_start = 1'b0; upd_start = 1'b0; upd_slot = '0;
        host_we = 1'b0; host_addr = '0; host_data = '0;
        repeat (3) tick();
        chk("rst_fm_we", 32'(fm_we), 32'd0);
        chk("rst_w_we", 32'(w_we), 32'd0);
        chk("rst_b_we", 32'(b_we), 32'd0);
        chk("rst_rd_en", 32'(src_rd_en), 32'd0);
        chk("rst_src_addr", 32'(src_addr), 32'd0);
        chk("rst_fm_wdata", 32'(fm_wdata), 32'd0);
        chk("rst_flags", {busy, init_done, upd_done, upd_err}, 32'd0);
        chk("rst_kidx", 32'(kernel_idx), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd1);
        rst = 1'b1;
        tick();

        reject(0, "upd_before_init");
        run_init(1'b1, 1'b0);
        reject(2, "upd_bad_slot");
        chk("kidx_after_bad_slot", 32'(kernel_idx), 32'd2);
        run_upd(0, 2);
        reject(1, "upd_exhausted");

        // Reset sampled at the edge ending cycle 5 of an initial load
        for (int i = 0; i < 4; i++) fm_q.push_back(mk(i, i));
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        chk("abort_enables", {fm_we, w_we, b_we, src_rd_en}, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_init_done", 32'(init_done), 32'd0);
        chk("abort_kidx", 32'(kernel_idx), 32'd0);
        rst = 1'b1;
        tick();
        queues_empty("abort");

        run_init(1'b0, 1'b0);
        run_init(1'b0, 1'b1);
        run_upd(1, 2);
        repeat (3) tick();
        queues_empty("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
